atm_ledger_arbiter: RTL



---
 rtl/atm_ledger_pkg.sv | 29 ++
 rtl/atm_ledger_arbiter_rr.sv | 44 ++++
 rtl/atm_ledger_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/atm_ledger_pkg.sv
// Shared constants and types for the ATM ledger arbiter.
// Opcodes, status codes, FSM states and power-on balances.
package atm_ledger_pkg;

  localparam int N_ACC = 4;
  localparam int ACC_W = 2;

  localparam logic [1:0] OP_READ     = 2'b00;
  localparam logic [1:0] OP_WITHDRAW = 2'b01;
  localparam logic [1:0] OP_TRANSFER = 2'b10;
  localparam logic [1:0] OP_DEPOSIT  = 2'b11;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_ARG   = 2'b01;
  localparam logic [1:0] ST_FUNDS = 2'b10;
  localparam logic [1:0] ST_OVF   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_EXEC,
    S_RESP
  } state_t;

  // Index 0 is the rightmost element.
  localparam logic [N_ACC-1:0][7:0] INIT_BAL =
    {8'd40, 8'd200, 8'd175, 8'd50};

endpackage

// File: rtl/atm_ledger_arbiter_rr.sv
// Round-robin picker: first requester at or after the pointer.
// Ports: clk, rst, req, upd_en, upd_idx -> pick_idx, pick_vld.
module atm_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          upd_en,
  input  logic [IW-1:0] upd_idx,
  output logic [IW-1:0] pick_idx,
  output logic          pick_vld
);

  logic [IW-1:0] ptr;

  // Scan offsets high to low so the nearest one wins.
  always_comb begin
    int j;
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (req[j]) begin
        pick_idx = IW'(j);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (upd_en) begin
      if (upd_idx == IW'(N - 1))
        ptr <= '0;
      else
        ptr <= upd_idx + IW'(1);
    end
  end

endmodule

// File: rtl/atm_ledger_arbiter.sv
// Shared 4-account ledger with round-robin atomic ops.
// Ports: clk, rst, req/op/src_idx/dst_idx/amt -> gnt, done, status, rd_bal, busy.
module atm_ledger_arbiter
  import atm_ledger_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int BAL_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [2*N_REQ-1:0]     src_idx,
  input  logic [2*N_REQ-1:0]     dst_idx,
  input  logic [BAL_W*N_REQ-1:0] amt,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [1:0]             status,
  output logic [BAL_W-1:0]       rd_bal,
  output logic                   busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t            state;
  logic [IW-1:0]     win;
  logic [1:0]        l_op;
  logic [ACC_W-1:0]  l_src;
  logic [ACC_W-1:0]  l_dst;
  logic [BAL_W-1:0]  l_amt;
  logic [BAL_W-1:0]  bal [N_ACC];

  logic [IW-1:0]     pick_idx;
  logic              pick_vld;

  logic [BAL_W-1:0]  bal_s;
  logic [BAL_W-1:0]  bal_d;
  logic [BAL_W:0]    sum_s;
  logic [BAL_W:0]    sum_d;
  logic [1:0]        ex_st;
  logic              wr_s;
  logic              wr_d;
  logic [BAL_W-1:0]  new_s;
  logic [BAL_W-1:0]  new_d;

  atm_rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .upd_en   (state == S_RESP),
    .upd_idx  (win),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  // Read-check-write datapath; one extra bit catches overflow.
  always_comb begin
    bal_s = bal[l_src];
    bal_d = bal[l_dst];
    sum_s = {1'b0, bal_s} + {1'b0, l_amt};
    sum_d = {1'b0, bal_d} + {1'b0, l_amt};
    ex_st = ST_OK;
    wr_s  = 1'b0;
    wr_d  = 1'b0;
    new_s = bal_s;
    new_d = bal_d;
    unique case (1'b1)
      (l_op == OP_READ): begin
        ex_st = ST_OK;
      end
      (l_op == OP_WITHDRAW): begin
        if (l_amt == '0) begin
          ex_st = ST_ARG;
        end else if (l_amt > bal_s) begin
          ex_st = ST_FUNDS;
        end else begin
          wr_s  = 1'b1;
          new_s = bal_s - l_amt;
        end
      end
      (l_op == OP_DEPOSIT): begin
        if (l_amt == '0) begin
          ex_st = ST_ARG;
        end else if (sum_s[BAL_W]) begin
          ex_st = ST_OVF;
        end else begin
          wr_s  = 1'b1;
          new_s = sum_s[BAL_W-1:0];
        end
      end
      (l_op == OP_TRANSFER): begin
        if (l_amt == '0 || l_src == l_dst) begin
          ex_st = ST_ARG;
        end else if (l_amt > bal_s) begin
          ex_st = ST_FUNDS;
        end else if (sum_d[BAL_W]) begin
          ex_st = ST_OVF;
        end else begin
          wr_s  = 1'b1;
          wr_d  = 1'b1;
          new_s = bal_s - l_amt;
          new_d = sum_d[BAL_W-1:0];
        end
      end
      default: ex_st = ST_OK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      gnt    <= '0;
      done   <= '0;
      status <= ST_OK;
      rd_bal <= '0;
      busy   <= 1'b0;
      win    <= '0;
      l_op   <= OP_READ;
      l_src  <= '0;
      l_dst  <= '0;
      l_amt  <= '0;
      for (int i = 0; i < N_ACC; i++)
        bal[i] <= BAL_W'(INIT_BAL[i]);
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pick_vld) begin
            state <= S_GRANT;
            busy  <= 1'b1;
            gnt   <= N_REQ'(1) << pick_idx;
            win   <= pick_idx;
            l_op  <= op[2*int'(pick_idx) +: 2];
            l_src <= src_idx[2*int'(pick_idx) +: 2];
            l_dst <= dst_idx[2*int'(pick_idx) +: 2];
            l_amt <= amt[BAL_W*int'(pick_idx) +: BAL_W];
          end
        end
        S_GRANT: begin
          state <= S_EXEC;
        end
        S_EXEC: begin
          state  <= S_RESP;
          done   <= N_REQ'(1) << win;
          status <= ex_st;
          rd_bal <= new_s;
          if (wr_s) bal[l_src] <= new_s;
          if (wr_d) bal[l_dst] <= new_d;
        end
        S_RESP: begin
          state <= S_IDLE;
          done  <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
